rf_operand_reader: RTL and testbench
====================================

Name: rf_operand_reader

Overview:
Decode-side consumer of the writeback interface. Holds the 32x32 integer register file and accepts the writeback write port (enable, address, data). It reads rs1/rs2 for the instruction in decode and applies same-cycle WB bypass. A pending-write scoreboard stalls RAW hazards, and operands are registered into a valid/ready output stage toward execute.

Parameters:
- XLEN, 32, register and data width.
- PEND_W, 2, width of the per-register pending-write counter; max outstanding writes per rd = 2^PEND_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  decode has an instruction.
- o_ready  out  1  reader accepts the instruction this cycle.
- i_rs1_addr  in  5  source 1 index.
- i_rs2_addr  in  5  source 2 index.
- i_rd_addr  in  5  destination index.
- i_rd_wr  in  1  instruction will write rd.
- i_flush  in  1  kill the output stage and block accept this cycle.
- i_wb_en  in  1  writeback write enable (rf write strobe).
- i_wb_addr  in  5  writeback destination.
- i_wb_data  in  XLEN  writeback data.
- o_valid  out  1  output stage holds an instruction.
- i_ready  in  1  execute accepts the output stage.
- o_rs1_data  out  XLEN  registered operand 1.
- o_rs2_data  out  XLEN  registered operand 2.
- o_rd_addr  out  5  registered rd.
- o_rd_wr  out  1  registered rd write flag.
- o_stall  out  1  i_valid & ~o_ready, for hazard visibility.

Behaviour:
Reset:
- rst clears all 31 registers (x1..x31) and all pending counters.
- Outputs reset: o_valid=0, o_rs1_data=0, o_rs2_data=0, o_rd_addr=0, o_rd_wr=0.
- Reset asserted mid-operation discards the output stage immediately.

Register file:
- x0 reads 0; writes to x0 are ignored and never touch the scoreboard.
- Write on a clock edge when i_wb_en is high.
- Read is combinational with bypass: if i_wb_en and i_wb_addr==rs (rs≠0), read data = i_wb_data.

Scoreboard:
- pend[r] increments on output handoff (o_valid & i_ready & o_rd_wr & o_rd_addr≠0).
- pend[r] decrements on i_wb_en & i_wb_addr==r.
- Increment and decrement to the same r in one cycle: no net change.
- Decrement when pend==0: no change (saturate at 0).

Hazard: high if any of the following holds.
- For rs in {rs1, rs2} with rs≠0: pend[rs] minus (wb hits rs this cycle ? 1 : 0) > 0.
- o_valid & o_rd_wr & o_rd_addr==rs (producer not yet handed off).
- i_rd_wr & pend[rd]==max (counter would overflow).

Handshake:
- o_ready = ~i_flush & ~hazard & (~o_valid | i_ready).
- Accept = i_valid & o_ready. Latency is 1 cycle: on accept the output register loads bypassed rs data, rd, rd_wr, and sets o_valid=1.
- Handoff without a new accept: o_valid=0.
- o_valid & ~i_ready: hold all outputs stable; o_ready=0.
- i_flush: o_valid cleared next edge with no scoreboard increment, and no accept. Flush takes priority over handoff.
- o_ready may depend combinationally on i_ready and i_wb_*; there is no combinational path from i_valid to o_ready.

Test Plan:
- Reset → all outputs 0. Issue rs1=0, rs2=0 → o_rs1_data = o_rs2_data = 0 one cycle later.
- WB write x5=0xDEADBEEF in the same cycle as accepting rs1=5 → o_rs1_data=0xDEADBEEF (bypass). A later read of x5 returns the same value.
- Issue I1 rd=7 (rd_wr), then I2 rs1=7 → I2 stalled while I1 sits in the output stage and while pend[7]=1. A WB to x7=0x1234 releases I2 in the same cycle, giving o_rs1_data=0x1234.
- Hold i_ready=0 for 3 cycles with o_valid=1 → outputs stable, o_ready=0, o_stall=1 if i_valid. Then i_ready=1 → handoff, and the next instruction is accepted in the same cycle.
- Three handoffs writing rd=3 with no WB (pend=3, max at PEND_W=2) → a fourth rd=3 writer is stalled. One WB to x3 → stall releases.
- i_flush with o_valid=1, o_rd_wr=1, rd=9 → o_valid=0 next cycle, pend[9] stays 0, and a following rs1=9 reader is not stalled.

Source files
------------

// File: rtl/rf_operand_reader.sv
// Decode-side operand reader: 32x32 register file with writeback bypass, a
// per-register pending-write scoreboard for RAW stalls, and a valid/ready output stage.
module rf_operand_reader #(
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_wr,
  input  logic            i_flush,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [4:0]      o_rd_addr,
  output logic            o_rd_wr,
  output logic            o_stall
);

  localparam int              CW       = PEND_W + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [XLEN-1:0]   rf_q   [32];
  logic [PEND_W-1:0] pend_q [32];
  logic [PEND_W-1:0] pend_d [32];

  logic            valid_q, valid_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_wr_q, rd_wr_d;

  logic [XLEN-1:0] rs1_rd_s, rs2_rd_s;
  logic            rs1_hit_s, rs2_hit_s;
  logic            rs1_haz_s, rs2_haz_s, ovf_haz_s, hazard_s;
  logic [CW-1:0]   rd_cnt_s;
  logic            handoff_s, ready_s, accept_s;
  logic [31:0]     inc_s, wb_hit_s;

  // Register file write port; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) rf_q[r] <= '0;
    end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
      rf_q[i_wb_addr] <= i_wb_data;
    end
  end

  // Combinational source read with same-cycle writeback bypass.
  always_comb begin
    rs1_hit_s = i_wb_en && (i_wb_addr == i_rs1_addr) && (i_rs1_addr != 5'd0);
    rs2_hit_s = i_wb_en && (i_wb_addr == i_rs2_addr) && (i_rs2_addr != 5'd0);
    if (i_rs1_addr == 5'd0) rs1_rd_s = '0;
    else if (rs1_hit_s)     rs1_rd_s = i_wb_data;
    else                    rs1_rd_s = rf_q[i_rs1_addr];
    if (i_rs2_addr == 5'd0) rs2_rd_s = '0;
    else if (rs2_hit_s)     rs2_rd_s = i_wb_data;
    else                    rs2_rd_s = rf_q[i_rs2_addr];
  end

  // Hazard detection: outstanding writes, producer still in the output stage, counter overflow.
  always_comb begin
    rs1_haz_s = (i_rs1_addr != 5'd0) &&
                ((pend_q[i_rs1_addr] > PEND_W'(rs1_hit_s)) ||
                 (valid_q && rd_wr_q && (rd_q == i_rs1_addr)));
    rs2_haz_s = (i_rs2_addr != 5'd0) &&
                ((pend_q[i_rs2_addr] > PEND_W'(rs2_hit_s)) ||
                 (valid_q && rd_wr_q && (rd_q == i_rs2_addr)));
    // A same-rd writer still in the output stage will be counted at handoff, so include it.
    rd_cnt_s  = {1'b0, pend_q[i_rd_addr]} + CW'(valid_q && rd_wr_q && (rd_q == i_rd_addr));
    ovf_haz_s = i_rd_wr && (i_rd_addr != 5'd0) && (rd_cnt_s >= {1'b0, PEND_MAX});
    hazard_s  = rs1_haz_s || rs2_haz_s || ovf_haz_s;
  end

  // Handshake terms; flush blocks both accept and handoff.
  always_comb begin
    handoff_s = valid_q && i_ready && !i_flush;
    ready_s   = !i_flush && !hazard_s && (!valid_q || i_ready);
    accept_s  = i_valid && ready_s;
  end

  // Scoreboard next state: +1 on handoff of a writer, -1 on writeback, saturating at zero.
  always_comb begin
    inc_s    = '0;
    wb_hit_s = '0;
    for (int r = 0; r < 32; r++) begin
      pend_d[r]   = pend_q[r];
      inc_s[r]    = handoff_s && rd_wr_q && (rd_q == 5'(r)) && (r != 0);
      wb_hit_s[r] = i_wb_en && (i_wb_addr == 5'(r)) && (r != 0);
      if (inc_s[r] && !wb_hit_s[r]) begin
        pend_d[r] = pend_q[r] + PEND_W'(1);
      end else if (wb_hit_s[r] && !inc_s[r] && (pend_q[r] != '0)) begin
        pend_d[r] = pend_q[r] - PEND_W'(1);
      end else begin
        pend_d[r] = pend_q[r];
      end
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) pend_q[r] <= pend_d[r];
    end
  end

  // Output stage next state: flush > accept > handoff > hold.
  always_comb begin
    valid_d = valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rd_wr_d = rd_wr_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      rs1_d   = rs1_rd_s;
      rs2_d   = rs2_rd_s;
      rd_d    = i_rd_addr;
      rd_wr_d = i_rd_wr;
    end else if (handoff_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= 5'd0;
      rd_wr_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd_wr_q <= rd_wr_d;
    end
  end

  assign o_ready    = ready_s;
  assign o_stall    = i_valid && !ready_s;
  assign o_valid    = valid_q;
  assign o_rs1_data = rs1_q;
  assign o_rs2_data = rs2_q;
  assign o_rd_addr  = rd_q;
  assign o_rd_wr    = rd_wr_q;

endmodule

// File: tb/tb_rf_operand_reader.sv
// Directed bench for rf_operand_reader: bypass, RAW stall, backpressure,
// scoreboard overflow, flush and asynchronous reset.
module tb_rf_operand_reader;

  logic        clk, rst;
  logic        i_valid, o_ready;
  logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr;
  logic        i_rd_wr, i_flush;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_valid, i_ready;
  logic [31:0] o_rs1_data, o_rs2_data;
  logic [4:0]  o_rd_addr;
  logic        o_rd_wr, o_stall;

  int total = 0;
  int bad   = 0;

  rf_operand_reader #(.XLEN(32), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .i_rd_addr(i_rd_addr), .i_rd_wr(i_rd_wr), .i_flush(i_flush),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_rd_addr(o_rd_addr), .o_rd_wr(o_rd_wr), .o_stall(o_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_valid = 1'b0; i_rs1_addr = 5'd0; i_rs2_addr = 5'd0; i_rd_addr = 5'd0;
    i_rd_wr = 1'b0; i_flush = 1'b0; i_wb_en = 1'b0; i_wb_addr = 5'd0;
    i_wb_data = 32'd0; i_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", o_valid); end
    total++; if (o_rs1_data !== 32'd0) begin bad++; $display("FAIL rst_rs1 got=%h exp=0", o_rs1_data); end
    total++; if (o_rs2_data !== 32'd0) begin bad++; $display("FAIL rst_rs2 got=%h exp=0", o_rs2_data); end
    total++; if (o_rd_addr !== 5'd0) begin bad++; $display("FAIL rst_rd got=%h exp=0", o_rd_addr); end
    total++; if (o_rd_wr !== 1'b0) begin bad++; $display("FAIL rst_rdwr got=%h exp=0", o_rd_wr); end
    rst = 1'b0;
    // x0 read while writeback targets x0: bypass must not apply
    i_valid = 1'b1; i_wb_en = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'hFFFF_FFFF;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%h exp=1", o_ready); end
    @(negedge clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL x0_valid got=%h exp=1", o_valid); end
    total++; if (o_rs1_data !== 32'd0) begin bad++; $display("FAIL x0_rs1 got=%h exp=0", o_rs1_data); end
    total++; if (o_rs2_data !== 32'd0) begin bad++; $display("FAIL x0_rs2 got=%h exp=0", o_rs2_data); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    i_valid = 1'b1; i_rs1_addr = 5'd5;
    i_wb_en = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%h exp=1", o_valid); end
    total++; if (o_rs1_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_rs1 got=%h exp=deadbeef", o_rs1_data); end
    i_wb_en = 1'b0; i_rs1_addr = 5'd0; i_rs2_addr = 5'd5;
    @(negedge clk);
    total++; if (o_rs2_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rf_rs2 got=%h exp=deadbeef", o_rs2_data); end
    total++; if (o_rs1_data !== 32'd0) begin bad++; $display("FAIL rf_rs1 got=%h exp=0", o_rs1_data); end
    idle_inputs();
    @(negedge clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL byp_drain got=%h exp=0", o_valid); end
  endtask

  task automatic test_raw();
    i_valid = 1'b1; i_rd_addr = 5'd7; i_rd_wr = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    total++; if (o_rd_addr !== 5'd7) begin bad++; $display("FAIL raw_i1_rd got=%h exp=7", o_rd_addr); end
    total++; if (o_rd_wr !== 1'b1) begin bad++; $display("FAIL raw_i1_rdwr got=%h exp=1", o_rd_wr); end
    i_rs1_addr = 5'd7; i_rd_addr = 5'd0; i_rd_wr = 1'b0;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL raw_busy_ready got=%h exp=0", o_ready); end
    total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL raw_busy_stall got=%h exp=1", o_stall); end
    @(negedge clk);
    i_ready = 1'b1;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL raw_prod_ready got=%h exp=0", o_ready); end
    @(negedge clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL raw_handoff got=%h exp=0", o_valid); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL raw_pend_ready got=%h exp=0", o_ready); end
    i_wb_en = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'h0000_1234;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL raw_release got=%h exp=1", o_ready); end
    @(negedge clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL raw_i2_valid got=%h exp=1", o_valid); end
    total++; if (o_rs1_data !== 32'h0000_1234) begin bad++; $display("FAIL raw_i2_rs1 got=%h exp=1234", o_rs1_data); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1; i_rs1_addr = 5'd5; i_rs2_addr = 5'd7; i_ready = 1'b0;
    @(negedge clk);
    i_rs1_addr = 5'd7; i_rs2_addr = 5'd5;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%h exp=0", k, o_ready); end
      total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL bp_stall[%0d] got=%h exp=1", k, o_stall); end
      total++; if (o_rs1_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bp_rs1[%0d] got=%h exp=deadbeef", k, o_rs1_data); end
      total++; if (o_rs2_data !== 32'h0000_1234) begin bad++; $display("FAIL bp_rs2[%0d] got=%h exp=1234", k, o_rs2_data); end
      @(negedge clk);
    end
    i_ready = 1'b1;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_go_ready got=%h exp=1", o_ready); end
    @(negedge clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%h exp=1", o_valid); end
    total++; if (o_rs1_data !== 32'h0000_1234) begin bad++; $display("FAIL bp_next_rs1 got=%h exp=1234", o_rs1_data); end
    total++; if (o_rs2_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bp_next_rs2 got=%h exp=deadbeef", o_rs2_data); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_overflow();
    i_valid = 1'b1; i_rd_addr = 5'd3; i_rd_wr = 1'b1;
    repeat (3) @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%h exp=0", o_valid); end
    i_valid = 1'b1;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%h exp=0", o_ready); end
    total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL ovf_stall got=%h exp=1", o_stall); end
    @(negedge clk);
    i_wb_en = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'h0000_0033;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL ovf_wb_ready got=%h exp=0", o_ready); end
    @(negedge clk);
    i_wb_en = 1'b0;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL ovf_release got=%h exp=1", o_ready); end
    @(negedge clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL ovf_w4_valid got=%h exp=1", o_valid); end
    total++; if (o_rd_addr !== 5'd3) begin bad++; $display("FAIL ovf_w4_rd got=%h exp=3", o_rd_addr); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_flush();
    i_valid = 1'b1; i_rd_addr = 5'd9; i_rd_wr = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    total++; if (o_rd_addr !== 5'd9) begin bad++; $display("FAIL fl_rd got=%h exp=9", o_rd_addr); end
    i_valid = 1'b0; i_flush = 1'b1; i_ready = 1'b1;
    #1;
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%h exp=0", o_ready); end
    @(negedge clk);
    i_flush = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%h exp=0", o_valid); end
    i_valid = 1'b1; i_rs1_addr = 5'd9; i_rd_addr = 5'd0; i_rd_wr = 1'b0;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL fl_reader_ready got=%h exp=1", o_ready); end
    total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL fl_reader_stall got=%h exp=0", o_stall); end
    @(negedge clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL fl_reader_valid got=%h exp=1", o_valid); end
    total++; if (o_rs1_data !== 32'd0) begin bad++; $display("FAIL fl_reader_rs1 got=%h exp=0", o_rs1_data); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    i_valid = 1'b1; i_rs1_addr = 5'd5; i_ready = 1'b0;
    @(negedge clk);
    total++; if (o_rs1_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mid_pre_rs1 got=%h exp=deadbeef", o_rs1_data); end
    #2 rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%h exp=0", o_valid); end
    total++; if (o_rs1_data !== 32'd0) begin bad++; $display("FAIL mid_rs1 got=%h exp=0", o_rs1_data); end
    @(negedge clk);
    rst = 1'b0;
    // pend[3] was left at max before reset; a new rd=3 writer must not stall
    i_ready = 1'b1; i_rd_addr = 5'd3; i_rd_wr = 1'b1;
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_pend_clr got=%h exp=1", o_ready); end
    @(negedge clk);
    total++; if (o_rs1_data !== 32'd0) begin bad++; $display("FAIL mid_rf_clr got=%h exp=0", o_rs1_data); end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_raw();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
